// File: rtl/int_pkg.sv
// Shared constants for the interrupt priority controller: register word
// addresses and the width of a source ID.
package int_pkg;

  localparam int INT_A_ENABLE    = 0;
  localparam int INT_A_THRESH    = 1;
  localparam int INT_A_PEND      = 2;
  localparam int INT_A_CLAIM     = 3;
  localparam int INT_A_PRIO_BASE = 4;

  localparam int INT_ID_W = 5;

  typedef logic [INT_ID_W-1:0] int_id_t;

endpackage

// File: rtl/int_prio_arb.sv
// Combinational arbiter: picks the eligible source with the highest priority,
// lowest ID on ties; ID 0 when nothing is eligible.
module int_prio_arb
  import int_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic [NSRC*PRIO_W-1:0] prio,
  input  logic [NSRC-1:0]        elig,
  output int_id_t                best_id
);

  logic [PRIO_W-1:0] best_prio;

  // Strict greater-than keeps the earlier (lower) ID when priorities tie.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (elig[i] && (best_id == '0 || prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_id   = int_id_t'(i + 1);
        best_prio = prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/int_prio_ctrl.sv
// Interrupt priority controller: register file, level gateway into pending
// bits, and the claim/complete handshake around the priority arbiter.
module int_prio_ctrl
  import int_pkg::*;
#(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_en,
  input  logic              reg_wr,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [63:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  input  logic [NSRC-1:0]   irq_src,
  output logic              irq_out,
  output logic [4:0]        irq_id
);

  logic [NSRC*PRIO_W-1:0] prio_q, prio_d;
  logic [NSRC-1:0]        enable_q, enable_d;
  logic [PRIO_W-1:0]      thresh_q, thresh_d;
  logic [NSRC-1:0]        pend_q, pend_d;
  logic [NSRC-1:0]        infl_q, infl_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   irq_out_q, irq_out_d;
  int_id_t                irq_id_q, irq_id_d;

  logic [NSRC-1:0] elig;
  int_id_t         best_id;
  int_id_t         cpl_id;
  logic            rd_acc, wr_acc, claim, complete;
  logic            unused_wdata;

  assign rd_acc       = reg_en && !reg_wr;
  assign wr_acc       = reg_en && reg_wr;
  assign claim        = rd_acc && (reg_addr == ADDR_W'(INT_A_CLAIM));
  assign complete     = wr_acc && (reg_addr == ADDR_W'(INT_A_CLAIM));
  assign cpl_id       = reg_wdata[INT_ID_W-1:0];
  assign unused_wdata = ^reg_wdata;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NSRC; i++) begin
      elig[i] = pend_q[i] && enable_q[i] && (prio_q[i*PRIO_W +: PRIO_W] > thresh_q);
    end
  end

  int_prio_arb #(
    .NSRC   (NSRC),
    .PRIO_W (PRIO_W)
  ) u_arb (
    .prio    (prio_q),
    .elig    (elig),
    .best_id (best_id)
  );

  always_comb begin
    enable_d = enable_q;
    thresh_d = thresh_q;
    prio_d   = prio_q;
    if (wr_acc) begin
      if (reg_addr == ADDR_W'(INT_A_ENABLE)) enable_d = reg_wdata[NSRC-1:0];
      if (reg_addr == ADDR_W'(INT_A_THRESH)) thresh_d = reg_wdata[PRIO_W-1:0];
      for (int k = 0; k < NSRC; k++) begin
        if (reg_addr == ADDR_W'(INT_A_PRIO_BASE + k)) prio_d[k*PRIO_W +: PRIO_W] = reg_wdata[PRIO_W-1:0];
      end
    end
  end

  // The gateway looks at the pre-complete in-flight bits, and a claim
  // overrides a same-cycle gateway set on the claimed source.
  always_comb begin
    pend_d = pend_q | (irq_src & ~infl_q);
    infl_d = infl_q;
    for (int i = 0; i < NSRC; i++) begin
      if (claim && best_id == int_id_t'(i + 1)) begin
        pend_d[i] = 1'b0;
        infl_d[i] = 1'b1;
      end
      if (complete && cpl_id == int_id_t'(i + 1)) infl_d[i] = 1'b0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) begin
      rdata_d = '0;
      if (reg_addr == ADDR_W'(INT_A_ENABLE)) rdata_d[NSRC-1:0]     = enable_q;
      if (reg_addr == ADDR_W'(INT_A_THRESH)) rdata_d[PRIO_W-1:0]   = thresh_q;
      if (reg_addr == ADDR_W'(INT_A_PEND))   rdata_d[NSRC-1:0]     = pend_q;
      if (reg_addr == ADDR_W'(INT_A_CLAIM))  rdata_d[INT_ID_W-1:0] = best_id;
      for (int k = 0; k < NSRC; k++) begin
        if (reg_addr == ADDR_W'(INT_A_PRIO_BASE + k)) rdata_d[PRIO_W-1:0] = prio_q[k*PRIO_W +: PRIO_W];
      end
    end
  end

  always_comb begin
    irq_id_d  = best_id;
    irq_out_d = (best_id != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q    <= '0;
      enable_q  <= '0;
      thresh_q  <= '0;
      pend_q    <= '0;
      infl_q    <= '0;
      rdata_q   <= '0;
      irq_out_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      enable_q  <= enable_d;
      thresh_q  <= thresh_d;
      pend_q    <= pend_d;
      infl_q    <= infl_d;
      rdata_q   <= rdata_d;
      irq_out_q <= irq_out_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign irq_out   = irq_out_q;
  assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_int_prio_ctrl.sv
// Bench for int_prio_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against an ID-level model.
module tb_int_prio_ctrl;

  localparam int NSRC   = 8;
  localparam int PRIO_W = 3;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              reg_en = 1'b0;
  logic              reg_wr = 1'b0;
  logic [ADDR_W-1:0] reg_addr = '0;
  logic [63:0]       reg_wdata = '0;
  logic [31:0]       reg_rdata;
  logic [NSRC-1:0]   irq_src = '0;
  logic              irq_out;
  logic [4:0]        irq_id;

  logic [NSRC-1:0] cur_src = '0;
  int total = 0;
  int bad   = 0;

  // Model state, indexed by source ID 1..NSRC
  int m_prio [1:NSRC];
  bit m_en   [1:NSRC];
  bit m_pend [1:NSRC];
  bit m_infl [1:NSRC];
  bit m_set  [1:NSRC];
  int m_thr;
  int e_rdata;
  int e_irq_id;
  bit e_irq_out;
  bit m_valid = 1'b0;
  int mb, ma, mw;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;

  always #5 clk = ~clk;

  int_prio_ctrl #(
    .NSRC   (NSRC),
    .PRIO_W (PRIO_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_en    (reg_en),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq_src   (irq_src),
    .irq_out   (irq_out),
    .irq_id    (irq_id)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest priority among eligible sources first, then the lowest ID holding it.
  function automatic int model_best();
    int top = 0;
    int id  = 0;
    for (int k = 1; k <= NSRC; k++)
      if (m_pend[k] && m_en[k] && m_prio[k] > m_thr && m_prio[k] > top) top = m_prio[k];
    if (top == 0) return 0;
    for (int k = 1; k <= NSRC; k++)
      if (id == 0 && m_pend[k] && m_en[k] && m_prio[k] == top) id = k;
    return id;
  endfunction

  function automatic int model_read(input int a, input int best);
    int v = 0;
    if (a == 0) for (int k = 1; k <= NSRC; k++) v += m_en[k] ? (1 << (k - 1)) : 0;
    else if (a == 1) v = m_thr;
    else if (a == 2) for (int k = 1; k <= NSRC; k++) v += m_pend[k] ? (1 << (k - 1)) : 0;
    else if (a == 3) v = best;
    else if (a >= 4 && a < 4 + NSRC) v = m_prio[a - 3];
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= NSRC; k++) begin
        m_prio[k] = 0; m_en[k] = 0; m_pend[k] = 0; m_infl[k] = 0;
      end
      m_thr = 0; e_rdata = 0; e_irq_id = 0; e_irq_out = 0;
      m_valid = 1'b1;
    end else begin
      mb = model_best();
      ma = int'(reg_addr);
      mw = int'(reg_wdata[31:0]);
      for (int k = 1; k <= NSRC; k++) m_set[k] = irq_src[k-1] && !m_pend[k] && !m_infl[k];
      if (reg_en && !reg_wr) e_rdata = model_read(ma, mb);
      if (reg_en && reg_wr) begin
        if (ma == 0) for (int k = 1; k <= NSRC; k++) m_en[k] = mw[k-1];
        if (ma == 1) m_thr = mw & ((1 << PRIO_W) - 1);
        if (ma >= 4 && ma < 4 + NSRC) m_prio[ma - 3] = mw & ((1 << PRIO_W) - 1);
        if (ma == 3 && (mw & 31) >= 1 && (mw & 31) <= NSRC) m_infl[mw & 31] = 0;
      end
      for (int k = 1; k <= NSRC; k++) if (m_set[k]) m_pend[k] = 1;
      if (reg_en && !reg_wr && ma == 3 && mb != 0) begin
        m_pend[mb] = 0;
        m_infl[mb] = 1;
      end
      e_irq_id  = mb;
      e_irq_out = (mb != 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_rdata", reg_rdata, 32'(e_rdata));
      checkOutput("model_irq_out", {31'b0, irq_out}, {31'b0, e_irq_out});
      checkOutput("model_irq_id", {27'b0, irq_id}, 32'(e_irq_id));
    end
  end

  task automatic applyStimulus(input logic en, input logic wr, input logic [ADDR_W-1:0] a,
                               input logic [31:0] d, input logic [NSRC-1:0] src);
    @(negedge clk);
    reg_en    = en;
    reg_wr    = wr;
    reg_addr  = a;
    reg_wdata = {32'hDEAD_BEEF, d};
    irq_src   = src;
  endtask

  task automatic wrReg(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, a, d, cur_src);
  endtask

  task automatic rdReg(input logic [ADDR_W-1:0] a);
    applyStimulus(1'b1, 1'b0, a, 32'h0, cur_src);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, 32'h0, cur_src);
  endtask

  task automatic rdCheck(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string name);
    rdReg(a);
    idle();
    checkOutput(name, reg_rdata, exp);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; reg_en = 1'b0; reg_wr = 1'b0; irq_src = cur_src;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    cur_src = '0;
    doReset();

    // Reset during a claim with two sources pending
    wrReg(6'd4, 32'd2); wrReg(6'd6, 32'd2); wrReg(6'd0, 32'h05);
    cur_src = 8'h05; idle(); cur_src = 8'h00; idle();
    rdCheck(6'd2, 32'h05, "rst_pre_pend");
    rdReg(6'd3); rst = 1'b1;
    idle(); rst = 1'b0;
    checkOutput("rst_rdata", reg_rdata, 32'h0);
    checkOutput("rst_irq_out", {31'b0, irq_out}, 32'h0);
    checkOutput("rst_irq_id", {27'b0, irq_id}, 32'h0);
    rdCheck(6'd2, 32'h0, "rst_pend");
    rdCheck(6'd0, 32'h0, "rst_enable");
    rdCheck(6'd4, 32'h0, "rst_prio1");

    // Basic pulse, claim, irq drop
    doReset();
    wrReg(6'd6, 32'd5); wrReg(6'd0, 32'h04); wrReg(6'd1, 32'd2);
    cur_src = 8'h04; idle(); cur_src = 8'h00; idle();
    checkOutput("basic_irq_lag", {31'b0, irq_out}, 32'h0);
    idle();
    checkOutput("basic_irq_out", {31'b0, irq_out}, 32'h1);
    checkOutput("basic_irq_id", {27'b0, irq_id}, 32'd3);
    rdCheck(6'd2, 32'h04, "basic_pend");
    rdCheck(6'd3, 32'd3, "basic_claim");
    checkOutput("basic_irq_hold", {31'b0, irq_out}, 32'h1);
    idle();
    checkOutput("basic_irq_drop", {31'b0, irq_out}, 32'h0);
    rdCheck(6'd2, 32'h0, "basic_pend_clr");

    // Priority order and lowest-ID tie-break
    doReset();
    wrReg(6'd4, 32'd4); wrReg(6'd5, 32'd6); wrReg(6'd8, 32'd6); wrReg(6'd0, 32'h13);
    cur_src = 8'h13; idle(); cur_src = 8'h00; idle(); idle();
    rdCheck(6'd3, 32'd2, "tie_claim_a");
    rdCheck(6'd3, 32'd5, "tie_claim_b");
    rdCheck(6'd3, 32'd1, "tie_claim_c");
    rdCheck(6'd3, 32'd0, "tie_claim_none");

    // Threshold and masking
    doReset();
    wrReg(6'd7, 32'd3); wrReg(6'd0, 32'h08); wrReg(6'd1, 32'd3);
    cur_src = 8'h08; idle(); cur_src = 8'h00; idle(); idle();
    checkOutput("thr_block", {31'b0, irq_out}, 32'h0);
    wrReg(6'd1, 32'd2); idle(); idle();
    checkOutput("thr_pass_id", {27'b0, irq_id}, 32'd4);
    wrReg(6'd0, 32'h00); idle(); idle();
    checkOutput("mask_drop", {31'b0, irq_out}, 32'h0);
    rdCheck(6'd2, 32'h08, "mask_pend_kept");

    // In-flight blocking and level re-trigger
    doReset();
    wrReg(6'd4, 32'd1); wrReg(6'd0, 32'h01);
    cur_src = 8'h01; idle(); idle();
    rdCheck(6'd3, 32'd1, "lvl_claim");
    rdCheck(6'd2, 32'h0, "lvl_blocked");
    wrReg(6'd3, 32'd9); wrReg(6'd3, 32'd0);
    rdCheck(6'd2, 32'h0, "lvl_bad_cpl");
    wrReg(6'd3, 32'd1);
    rdReg(6'd2); rdReg(6'd2);
    checkOutput("lvl_same_edge", reg_rdata, 32'h0);
    idle();
    checkOutput("lvl_repend", reg_rdata, 32'h01);
    cur_src = 8'h00;

    // Unmapped addresses and field widths
    doReset();
    wrReg(6'd40, 32'hFFFF_FFFF); wrReg(6'd2, 32'hFFFF_FFFF);
    rdCheck(6'd2, 32'h0, "wid_pend_ro");
    rdCheck(6'd40, 32'h0, "wid_unmapped");
    wrReg(6'd4, 32'hFF);
    rdCheck(6'd4, 32'h07, "wid_prio");
    wrReg(6'd0, 32'hFFFF_FFFF);
    rdCheck(6'd0, 32'hFF, "wid_enable");
    wrReg(6'd1, 32'h0000_FFFF);
    rdCheck(6'd1, 32'h07, "wid_thresh");

    // Randomized traffic, checked every cycle by the model
    doReset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) cur_src = NSRC'($urandom);
      r_addr = ($urandom_range(0, 3) != 0) ? ADDR_W'($urandom_range(0, 13)) : ADDR_W'($urandom_range(0, 63));
      r_data = $urandom;
      if (r_addr == 6'd3 && $urandom_range(0, 3) != 0) r_data = 32'($urandom_range(0, 10));
      if ($urandom_range(0, 499) == 0) doReset();
      else applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_addr, r_data, cur_src);
    end
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
